// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_arb_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        DB_ALU = 2'b00,
        DB_MEM = 2'b01,
        DB_PC4 = 2'b10
    } db_data_src_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for late multi-cycle results; exposes per-slot rd/valid
// so the arbiter can answer hazard queries against every buffered entry.
module wb_pend_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             push,
    input  wb_entry_t        push_ent,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic [4:0]       ent_rd [DEPTH],
    output logic [DEPTH-1:0] ent_vld
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            // push only happens below DEPTH and pop only above 0, so the two
            // slots touched in one cycle are never the same slot
            if (push) begin
                wr_ptr          <= next_ptr(wr_ptr);
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= next_ptr(rd_ptr);
                ent_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_ent;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between WB and a multi-cycle unit.
// Optional starvation guard: define WB_STARVE_GUARD_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        wb_valid,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_pending,
    output logic        rt_pending,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        wb_stall
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("wb_port_arbiter: DEPTH and STARVE_LIMIT must be >= 1");
    end

    wb_entry_t        head;
    wb_entry_t        push_ent;
    logic [CW-1:0]    count;
    logic             empty;
    logic [4:0]       ent_rd [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic             push;
    logic             pop;
    logic             pipe_req;
    logic             room;
    logic             starve_hit;
    logic             grant_head;
    logic             grant_pipe;
    logic             grant_mc;
    logic             forced;
    logic             rs_hit;
    logic             rt_hit;

    wb_pend_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .CLK      (CLK),
        .Reset    (Reset),
        .push     (push),
        .push_ent (push_ent),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .empty    (empty),
        .ent_rd   (ent_rd),
        .ent_vld  (ent_vld)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= STARVE_MAX) ? v : v + SW'(1);
    endfunction

    // counts how long the current head has waited; a new head starts at 0
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)              starve_cnt <= '0;
        else if (empty || pop)  starve_cnt <= '0;
        else                    starve_cnt <= sat_inc(starve_cnt);
    end

    assign starve_hit = !empty && (starve_cnt >= STARVE_MAX);
`else
    assign starve_hit = 1'b0;
`endif

    assign pipe_req = wb_valid && wb_regwrite && (wb_rd != REG_ZERO);
    assign room     = (count < DEPTH_C);

    always_comb begin
        grant_head = 1'b0;
        grant_pipe = 1'b0;
        grant_mc   = 1'b0;
        forced     = 1'b0;
        if (starve_hit) begin
            grant_head = 1'b1;
            forced     = 1'b1;
        end else if (pipe_req) begin
            grant_pipe = 1'b1;
        end else if (!empty) begin
            grant_head = 1'b1;
        end else if (mc_valid && mc_rd != REG_ZERO) begin
            grant_mc   = 1'b1;
        end
    end

    // rd==0 results are accepted but never stored; direct grants bypass the buffer
    assign push     = mc_valid && room && (mc_rd != REG_ZERO) && !grant_mc;
    assign pop      = grant_head;
    assign push_ent = '{rd: mc_rd, data: mc_data};

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_rd[i] == rs && rs != REG_ZERO) rs_hit = 1'b1;
            if (ent_vld[i] && ent_rd[i] == rt && rt != REG_ZERO) rt_hit = 1'b1;
        end
    end

    always_comb begin
        RegWrite  = 1'b0;
        WriteReg  = REG_ZERO;
        WriteData = '0;
        if (!Reset) begin
            if (grant_head) begin
                RegWrite  = 1'b1;
                WriteReg  = head.rd;
                WriteData = head.data;
            end else if (grant_pipe) begin
                RegWrite  = 1'b1;
                WriteReg  = wb_rd;
                WriteData = wb_data;
            end else if (grant_mc) begin
                RegWrite  = 1'b1;
                WriteReg  = mc_rd;
                WriteData = mc_data;
            end
        end
    end

    assign mc_ready   = room && !Reset;
    assign wb_stall   = forced && !Reset;
    assign rs_pending = rs_hit && !Reset;
    assign rt_pending = rt_hit && !Reset;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes are queued per cycle
// by each scenario and compared against the write port at every falling edge.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_pending;
    logic        rt_pending;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        wb_stall;

    int checks = 0;
    int errors = 0;

    wb_entry_t   exp_q [$];
    wb_entry_t   exp_e;
    logic        exp_v;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .CLK         (clk),
        .Reset       (rst),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mc_valid    (mc_valid),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .mc_ready    (mc_ready),
        .rs          (rs),
        .rt          (rt),
        .rs_pending  (rs_pending),
        .rt_pending  (rt_pending),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .wb_stall    (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write-port scoreboard: exactly the queued write (or no write) each cycle
    always @(negedge clk) begin
        if (!rst) begin
            exp_v = 1'b0;
            exp_e = '0;
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                exp_v = 1'b1;
            end
            checks++;
            if ({RegWrite, WriteReg, WriteData} !== {exp_v, exp_e.rd, exp_e.data}) begin
                errors++;
                $display("FAIL write_port t=%0t got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                         $time, RegWrite, WriteReg, WriteData, exp_v, exp_e.rd, exp_e.data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0; rs = 0; rt = 0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1; wb_regwrite = 1; wb_rd = rd; wb_data = d;
        exp_q.push_back('{rd: rd, data: d});
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        mc_valid = 1; mc_rd = 5'd5; mc_data = 32'hDEAD;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd4; wb_data = 32'h44;
        @(negedge clk);
        checks++;
        if ({RegWrite, WriteReg, WriteData, mc_ready, wb_stall, rs_pending, rt_pending} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b rd=%0d data=%h rdy=%0b stall=%0b want all 0",
                     RegWrite, WriteReg, WriteData, mc_ready, wb_stall);
        end
        idle();
        cyc();
        rst = 0;
        @(negedge clk);
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b want 1", mc_ready);
        end
        cyc();
    endtask

    task automatic test_direct();
        mc_valid = 1; mc_rd = 5'd5; mc_data = 32'h1234; rs = 5'd5;
        exp_q.push_back('{rd: 5'd5, data: 32'h1234});
        @(negedge clk);
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL direct_ready got %0b want 1", mc_ready);
        end
        cyc();
        mc_valid = 0;
        @(negedge clk);
        checks++;
        if ({rs_pending, mc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL direct_not_buffered got pend=%0b rdy=%0b want pend=0 rdy=1", rs_pending, mc_ready);
        end
        idle();
        cyc();
    endtask

    task automatic test_pending();
        rt = 5'd7;
        pipe(5'd3, 32'hA0);
        mc_valid = 1; mc_rd = 5'd7; mc_data = 32'h7777;
        @(negedge clk);
        cyc();
        mc_valid = 0;
        pipe(5'd3, 32'hA1);
        @(negedge clk);
        checks++;
        if (rt_pending !== 1'b1) begin
            errors++;
            $display("FAIL pending_set got %0b want 1", rt_pending);
        end
        cyc();
        wb_regwrite = 0;
        exp_q.push_back('{rd: 5'd7, data: 32'h7777});
        @(negedge clk);
        checks++;
        if (rt_pending !== 1'b1) begin
            errors++;
            $display("FAIL pending_during_drain got %0b want 1", rt_pending);
        end
        cyc();
        wb_valid = 0;
        @(negedge clk);
        checks++;
        if (rt_pending !== 1'b0) begin
            errors++;
            $display("FAIL pending_cleared got %0b want 0", rt_pending);
        end
        idle();
        cyc();
    endtask

    task automatic test_full();
        logic [3:0] rdy_seq;
        rdy_seq = 4'b1100;
        rs = 5'd8; rt = 5'd9;
        for (int i = 0; i < 4; i++) begin
            pipe(5'd3, 32'hB0 + i);
            mc_valid = 1;
            mc_rd    = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10;
            mc_data  = {27'd0, mc_rd};
            @(negedge clk);
            checks++;
            if (mc_ready !== rdy_seq[3 - i]) begin
                errors++;
                $display("FAIL full_ready_%0d got %0b want %0b", i, mc_ready, rdy_seq[3 - i]);
            end
            cyc();
        end
        wb_regwrite = 0;
        exp_q.push_back('{rd: 5'd8, data: 32'd8});
        @(negedge clk);
        checks++;
        if ({mc_ready, rs_pending, rt_pending} !== 3'b011) begin
            errors++;
            $display("FAIL full_pop_no_passthru got rdy=%0b rs=%0b rt=%0b want rdy=0 rs=1 rt=1",
                     mc_ready, rs_pending, rt_pending);
        end
        cyc();
        exp_q.push_back('{rd: 5'd9, data: 32'd9});
        @(negedge clk);
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_after_pop got %0b want 1", mc_ready);
        end
        cyc();
        mc_valid = 0;
        rs = 5'd10;
        exp_q.push_back('{rd: 5'd10, data: 32'd10});
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++;
        if (rs_pending !== 1'b0) begin
            errors++;
            $display("FAIL full_drained got %0b want 0", rs_pending);
        end
        idle();
        cyc();
    endtask

    task automatic test_starve();
        pipe(5'd3, 32'hC0);
        mc_valid = 1; mc_rd = 5'd12; mc_data = 32'hC;
        @(negedge clk);
        cyc();
        mc_valid = 0;
`ifdef WB_STARVE_GUARD_EN
        for (int k = 1; k <= 4; k++) begin
            pipe(5'd3, 32'hC0 + k);
            @(negedge clk);
            checks++;
            if (wb_stall !== 1'b0) begin
                errors++;
                $display("FAIL starve_wait_%0d got stall=%0b want 0", k, wb_stall);
            end
            cyc();
        end
        wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'hC5;
        exp_q.push_back('{rd: 5'd12, data: 32'hC});
        @(negedge clk);
        checks++;
        if (wb_stall !== 1'b1) begin
            errors++;
            $display("FAIL starve_forced got stall=%0b want 1", wb_stall);
        end
        cyc();
        pipe(5'd3, 32'hC5);
        @(negedge clk);
        checks++;
        if (wb_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_one_cycle got stall=%0b want 0", wb_stall);
        end
        cyc();
`else
        for (int k = 1; k <= 8; k++) begin
            pipe(5'd3, 32'hC0 + k);
            @(negedge clk);
            checks++;
            if (wb_stall !== 1'b0) begin
                errors++;
                $display("FAIL no_guard_stall_%0d got %0b want 0", k, wb_stall);
            end
            cyc();
        end
        wb_regwrite = 0;
        exp_q.push_back('{rd: 5'd12, data: 32'hC});
        @(negedge clk);
        cyc();
`endif
        idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_rd_zero();
        mc_valid = 1; mc_rd = 5'd0; mc_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (mc_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_accept got %0b want 1", mc_ready);
        end
        cyc();
        pipe(5'd3, 32'hD0);
        @(negedge clk);
        cyc();
        idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_reset_mid();
        rs = 5'd20;
        for (int i = 0; i < 2; i++) begin
            pipe(5'd3, 32'hE0 + i);
            mc_valid = 1; mc_rd = 5'd20 + i; mc_data = 32'hE00 + i;
            @(negedge clk);
            cyc();
        end
        idle();
        rs = 5'd20;
        rst = 1;
        #1;
        checks++;
        if ({RegWrite, WriteReg, WriteData, mc_ready, wb_stall, rs_pending} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got we=%0b rd=%0d rdy=%0b pend=%0b want all 0",
                     RegWrite, WriteReg, mc_ready, rs_pending);
        end
        cyc();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({mc_ready, rs_pending} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_release got rdy=%0b pend=%0b want rdy=1 pend=0", mc_ready, rs_pending);
        end
        cyc();
        @(negedge clk);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_direct();
        test_pending();
        test_full();
        test_starve();
        test_rd_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline's write-back stage and a multi-cycle execution unit, such as a multiply/divide unit, whose results return out of band. It sits between the WB-stage data select and the register file. Late results are held in a small pending buffer and drained into idle WB slots. An optional starvation guard stalls the pipeline for one slot when a buffered result has waited too long. It also reports pending destination registers to the hazard unit.

## Interface
- DEPTH, 2, pending-buffer entries (≥1)
- STARVE_LIMIT, 4, cycles a buffered head may wait before a forced grant
- CLK  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high
- wb_valid  input  1  WB stage holds a valid instruction
- wb_regwrite  input  1  that instruction writes a register
- wb_rd  input  5  its destination register
- wb_data  input  32  selected WB data (ALU / memory / PC+4)
- mc_valid  input  1  multi-cycle unit presents a result
- mc_rd  input  5  result destination register
- mc_data  input  32  result value
- mc_ready  output  1  arbiter accepts mc result this cycle
- rs, rt  input  5 each  hazard-unit query registers
- rs_pending, rt_pending  output  1 each  query register has a buffered, unwritten result
- RegWrite  output  1  register-file write enable
- WriteReg  output  5  register-file write address
- WriteData  output  32  register-file write data
- wb_stall  output  1  pipeline must hold its WB stage this cycle

## Operation
- pipe_req = wb_valid & wb_regwrite & (wb_rd != 0). A slot is free when !pipe_req.
- Grant priority is evaluated each cycle, combinationally from state and inputs:
  1. Starve: count>0 & starve_cnt ≥ STARVE_LIMIT. Grant head, pop, wb_stall=1, and suppress the pipeline write.
  2. pipe_req: grant pipeline (wb_rd, wb_data).
  3. count>0: grant head, pop.
  4. count==0 & mc_valid & mc_rd≠0: direct grant of the mc result; it is accepted and not enqueued.
  5. Otherwise RegWrite=0, and WriteReg/WriteData=0.
- mc_ready = (count < DEPTH). It is based on registered count and has no pop pass-through.
- Enqueue occurs on mc_valid & mc_ready, unless a direct grant (rule 4) applies. mc_rd==0 results are accepted and discarded.
- Pop and push in the same cycle: count unchanged, FIFO order kept.
- starve_cnt increments, saturating, each cycle count>0 and the head is not popped. It clears on pop or when count==0.
- rs_pending is 1 iff some valid entry has rd==rs and rs≠0. rt_pending is defined the same way for rt.
- A register written by a granted entry is no longer pending from the next cycle.

## Timing
- Reset (async) empties the buffer and clears starve_cnt. While Reset is high, all outputs are 0, including mc_ready. Buffered results are lost on reset mid-operation; the mc unit is reset with the arbiter.
- Grant decision and outputs are zero-latency combinational. Buffer state updates on the CLK rising edge.
- The mc result-to-write latency is 0 cycles when rule 4 applies. Otherwise it is ≥1 cycle.
- wb_stall lasts exactly one cycle per forced grant. The pipeline holds WB inputs stable, and its write is granted the following cycle.
- After a forced grant, starve_cnt restarts from 0 for the new head.

## Configuration
- WB_STARVE_GUARD_EN defined: rule 1 is active and wb_stall can assert.
- WB_STARVE_GUARD_EN undefined: starve_cnt and rule 1 are removed and wb_stall is tied to 0. Buffered results drain only in free slots, and back-pressure is provided solely by mc_ready.

## Structure
- Package wb_arb_pkg holds:
  - the entry typedef {rd[4:0], data[31:0]};
  - the DBDataSrc encodings (2'b00 ALU, 2'b01 memory, 2'b10 PC+4);
  - the register-0 constant.
- Sub-module wb_pend_fifo: DEPTH-entry FIFO with push/pop/count, head output, and per-entry rd/valid outputs for the pending compare.

## Test plan
- Free slot, empty buffer, mc_valid, mc_rd=5, mc_data=0x1234 → same cycle RegWrite=1, WriteReg=5, WriteData=0x1234; count stays 0.
- pipe_req rd=3 on every cycle, then mc result rd=7 → enqueued, rt=7 gives rt_pending=1. First cycle with wb_regwrite=0 → writes rd 7; rt_pending=0 next cycle.
- Buffer full (2 entries), mc_valid held → mc_ready=0 and no loss. After one pop → mc_ready=1 next cycle.
- Guard on, pipe_req every cycle, one buffered entry → after 4 waiting cycles, wb_stall=1 and the buffered write is granted. The pipeline write is granted the next cycle.
- mc_rd=0 with data 0xFFFF_FFFF → accepted, RegWrite stays 0, nothing buffered.
- Reset asserted with 2 entries pending → outputs 0 immediately; after release, count=0, mc_ready=1, rs_pending=0.
